// File: rtl/gp_register_file_mp.sv
// General-purpose register file: DATA_W x DEPTH, NUM_RD registered read ports, one write port.
// Hardwired zero register, sequential clear engine; optional write-to-read bypass via REGFILE_BYPASS_EN.
module gp_register_file_mp #(
   parameter  int DATA_W   = 32,
   parameter  int DEPTH    = 32,
   parameter  int NUM_RD   = 2,
   parameter  int ZERO_REG = 1,
   localparam int IDX_W    = $clog2(DEPTH)
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     clear_req,
   output logic                     ready,
   input  logic [NUM_RD*IDX_W-1:0]  rd_idx,
   output logic [NUM_RD*DATA_W-1:0] rd_data,
   input  logic                     wr_en,
   input  logic [IDX_W-1:0]         wr_idx,
   input  logic [DATA_W-1:0]        wr_data
);

   typedef enum logic {ST_CLEAR, ST_READY} state_t;

   localparam logic [IDX_W:0]   DEPTH_L = (IDX_W+1)'(DEPTH);
   localparam logic [IDX_W-1:0] LAST_L  = IDX_W'(DEPTH - 1);

   state_t                     state, state_nxt;
   logic [IDX_W-1:0]           clr_cnt, clr_cnt_nxt;
   logic [NUM_RD*DATA_W-1:0]   rd_q, rd_nxt;
   logic [DATA_W-1:0]          mem [DEPTH];
   logic [IDX_W-1:0]           ridx;
   logic                       wr_ok;

   // Index usable for storage: in range and not the hardwired zero register.
   function automatic logic idx_ok(input logic [IDX_W-1:0] idx);
      return ({1'b0, idx} < DEPTH_L) && !((ZERO_REG != 0) && (idx == '0));
   endfunction

   always_comb begin
      state_nxt   = state;
      clr_cnt_nxt = clr_cnt;
      rd_nxt      = '0;
      wr_ok       = 1'b0;
      ready       = 1'b0;
      ridx        = '0;
      case (state)
         ST_CLEAR: begin
            clr_cnt_nxt = clr_cnt + 1'b1;
            if (clear_req)
               clr_cnt_nxt = '0;
            else if (clr_cnt == LAST_L)
               state_nxt = ST_READY;
         end
         ST_READY: begin
            ready = 1'b1;
            wr_ok = wr_en && idx_ok(wr_idx);
            if (clear_req) begin
               state_nxt   = ST_CLEAR;
               clr_cnt_nxt = '0;
            end
            for (int unsigned p = 0; p < NUM_RD; p++) begin
               ridx = rd_idx[p*IDX_W +: IDX_W];
               if (idx_ok(ridx))
                  rd_nxt[p*DATA_W +: DATA_W] = mem[ridx];
`ifdef REGFILE_BYPASS_EN
               if (wr_ok && (wr_idx == ridx))
                  rd_nxt[p*DATA_W +: DATA_W] = wr_data;
`endif
            end
         end
         default: state_nxt = ST_CLEAR;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= ST_CLEAR;
         clr_cnt <= '0;
         rd_q    <= '0;
      end else begin
         state   <= state_nxt;
         clr_cnt <= clr_cnt_nxt;
         rd_q    <= rd_nxt;
      end
   end

   // Storage is not reset; the clear engine zeroes it one entry per cycle.
   always_ff @(posedge clk) begin
      if (state == ST_CLEAR)
         mem[clr_cnt] <= '0;
      else if (wr_ok)
         mem[wr_idx] <= wr_data;
   end

   assign rd_data = rd_q;

endmodule

// File: tb/tb_gp_register_file_mp.sv
// Self-checking bench for gp_register_file_mp: scoreboard of expected read data, ZERO_REG=1 and ZERO_REG=0 instances.
// Honours REGFILE_BYPASS_EN when the build defines it.
module tb_gp_register_file_mp;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        clear_req = 1'b0;
   logic [9:0]  rd_idx = '0;
   logic        wr_en = 1'b0;
   logic [4:0]  wr_idx = '0;
   logic [31:0] wr_data = '0;
   logic [63:0] rd_data, rd_data_nz;
   logic        ready, ready_nz;

   int n_chk = 0;
   int n_err = 0;
   int n;
   logic [31:0] m1 [32];
   logic [31:0] m0 [32];
   logic [31:0] exp_q [$];

   always #5 clk = ~clk;

   gp_register_file_mp #(.DATA_W(32), .DEPTH(32), .NUM_RD(2), .ZERO_REG(1)) u_dut (
      .clk(clk), .rst_n(rst_n), .clear_req(clear_req), .ready(ready),
      .rd_idx(rd_idx), .rd_data(rd_data),
      .wr_en(wr_en), .wr_idx(wr_idx), .wr_data(wr_data)
   );

   gp_register_file_mp #(.DATA_W(32), .DEPTH(32), .NUM_RD(2), .ZERO_REG(0)) u_dut_nz (
      .clk(clk), .rst_n(rst_n), .clear_req(clear_req), .ready(ready_nz),
      .rd_idx(rd_idx), .rd_data(rd_data_nz),
      .wr_en(wr_en), .wr_idx(wr_idx), .wr_data(wr_data)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic model_clear();
      for (int i = 0; i < 32; i++) begin
         m1[i] = '0;
         m0[i] = '0;
      end
   endtask

   // One READY cycle: drive read/write/clear, push expected read data, compare after the edge.
   task automatic rd_wr(input logic [4:0] a0, input logic [4:0] a1, input bit we,
                        input logic [4:0] wi, input logic [31:0] wd, input bit clr);
      logic [4:0]  a [2];
      logic [31:0] v;
      a[0] = a0;
      a[1] = a1;
      rd_idx = {a1, a0};
      wr_en = we;
      wr_idx = wi;
      wr_data = wd;
      clear_req = clr;
      for (int z = 1; z >= 0; z--) begin
         for (int p = 0; p < 2; p++) begin
            if (z == 1 && a[p] == 5'd0) v = '0;
            else v = (z == 1) ? m1[a[p]] : m0[a[p]];
`ifdef REGFILE_BYPASS_EN
            if (we && wi == a[p] && !(z == 1 && wi == 5'd0)) v = wd;
`endif
            exp_q.push_back(v);
         end
      end
      if (we) begin
         if (wi != 5'd0) m1[wi] = wd;
         m0[wi] = wd;
      end
      @(posedge clk); #1;
      wr_en = 1'b0;
      clear_req = 1'b0;
      chk("rd_z1_p0", rd_data[31:0], exp_q.pop_front());
      chk("rd_z1_p1", rd_data[63:32], exp_q.pop_front());
      chk("rd_z0_p0", rd_data_nz[31:0], exp_q.pop_front());
      chk("rd_z0_p1", rd_data_nz[63:32], exp_q.pop_front());
   endtask

   // Count edges until ready; optionally attempt a write to x4 after wr_at edges of clearing.
   task automatic wait_ready(input int wr_at, output int cnt);
      cnt = 0;
      while (!ready && cnt < 100) begin
         if (cnt == wr_at) begin
            wr_en = 1'b1;
            wr_idx = 5'd4;
            wr_data = 32'h77;
         end else begin
            wr_en = 1'b0;
         end
         @(posedge clk); #1;
         cnt++;
         if (cnt == 1) chk("clr_rd_zero", rd_data[31:0] | rd_data[63:32], 32'h0);
      end
      wr_en = 1'b0;
      chk("rdy_nz", {31'b0, ready_nz}, 32'h1);
   endtask

   initial begin
      #2 rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_rd", rd_data[31:0] | rd_data[63:32], 32'h0);
      chk("rst_rdy", {31'b0, ready}, 32'h0);
      rst_n = 1'b1;
      wait_ready(-1, n);
      chk("clr_lat", n, 32);
      model_clear();

      for (int i = 0; i < 32; i += 2)
         rd_wr(5'(i), 5'(i + 1), 1'b0, 5'd0, 32'h0, 1'b0);

      rd_wr(5'd5, 5'd5, 1'b1, 5'd5, 32'hDEADBEEF, 1'b0);
      rd_wr(5'd5, 5'd5, 1'b1, 5'd5, 32'h0, 1'b0);
      rd_wr(5'd5, 5'd6, 1'b0, 5'd0, 32'h0, 1'b0);

      rd_wr(5'd0, 5'd0, 1'b1, 5'd0, 32'h1234, 1'b0);
      rd_wr(5'd0, 5'd1, 1'b0, 5'd0, 32'h0, 1'b0);

      rd_wr(5'd6, 5'd6, 1'b1, 5'd7, 32'h11, 1'b0);
      rd_wr(5'd7, 5'd7, 1'b1, 5'd7, 32'hA5A5A5A5, 1'b0);
      rd_wr(5'd7, 5'd7, 1'b0, 5'd0, 32'h0, 1'b0);

      rd_wr(5'd3, 5'd3, 1'b1, 5'd3, 32'h55, 1'b0);
      rd_wr(5'd3, 5'd3, 1'b1, 5'd9, 32'h99, 1'b1);
      chk("clr_req_rdy", {31'b0, ready}, 32'h0);
      wait_ready(10, n);
      chk("clr_req_lat", n, 32);
      model_clear();
      rd_wr(5'd3, 5'd4, 1'b0, 5'd0, 32'h0, 1'b0);
      rd_wr(5'd9, 5'd7, 1'b0, 5'd0, 32'h0, 1'b0);

      rd_wr(5'd0, 5'd0, 1'b0, 5'd0, 32'h0, 1'b1);
      repeat (10) @(posedge clk);
      #3 rst_n = 1'b0;
      #1;
      chk("midclr_rdy", {31'b0, ready}, 32'h0);
      chk("midclr_rd", rd_data[31:0] | rd_data[63:32], 32'h0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      wait_ready(-1, n);
      chk("midclr_lat", n, 32);
      model_clear();

      rd_wr(5'd5, 5'd5, 1'b1, 5'd5, 32'h1, 1'b0);
      rd_wr(5'd5, 5'd5, 1'b0, 5'd0, 32'h0, 1'b0);
      #2 rst_n = 1'b0;
      #1;
      chk("midop_rd", rd_data[31:0] | rd_data[63:32], 32'h0);
      chk("midop_rd_nz", rd_data_nz[31:0] | rd_data_nz[63:32], 32'h0);
      chk("midop_rdy", {31'b0, ready}, 32'h0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      wait_ready(-1, n);
      chk("midop_lat", n, 32);
      model_clear();
      rd_wr(5'd5, 5'd0, 1'b0, 5'd0, 32'h0, 1'b0);

      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end

endmodule
